// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared AXI4-Lite response encodings and address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   // Drops the byte-offset bits so the result indexes whole data words.
   function automatic logic [63:0] word_index(input logic [63:0] addr,
                                              input int          data_width);
      logic [63:0] idx;
      case (data_width)
         16:      idx = addr >> 1;
         32:      idx = addr >> 2;
         64:      idx = addr >> 3;
         default: idx = addr;
      endcase
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_reg_array.sv
// ============================================================================
// Module      : axi_lite_reg_array
// Description : NUM_REGS x DATA_WIDTH storage with byte-strobed write port and
//               one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_reg_array #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 16,
   parameter int                    IDX_W       = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [IDX_W-1:0]        widx_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic [IDX_W-1:0]        ridx_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   localparam int               c_lanes = DATA_WIDTH / 8;
   localparam logic [IDX_W:0]   c_nregs = (IDX_W + 1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            mem_q[r] <= RESET_VALUE;
         end
      end else if (we_i) begin
         for (int l = 0; l < c_lanes; l++) begin
            if (wstrb_i[l]) begin
               mem_q[widx_i][8*l +: 8] <= wdata_i[8*l +: 8];
            end
         end
      end
   end

   // Non-power-of-two depths leave unused index codes; those read as zero.
   always_comb begin
      rdata_o = '0;
      if ({1'b0, ridx_i} < c_nregs) begin
         rdata_o = mem_q[ridx_i];
      end
   end

endmodule

`default_nettype wire

// File: rtl/axi_lite_regfile.sv
// ============================================================================
// Module      : axi_lite_regfile
// Description : Parametrised AXI4-Lite subordinate register file with byte
//               strobes, decoupled AW/W capture and SLVERR on bad addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    NUM_REGS    = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                    s_axi_clk,
   input  logic                    s_axi_reset,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int c_strb_w = DATA_WIDTH / 8;
   localparam int c_idx_w  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                  aw_full_q, aw_full_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                  w_full_q,  w_full_d;
   logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
   logic [c_strb_w-1:0]   w_strb_q,  w_strb_d;
   logic                  bvalid_q,  bvalid_d;
   resp_t                 bresp_q,   bresp_d;
   logic                  rvalid_q,  rvalid_d;
   resp_t                 rresp_q,   rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;

   logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata, w_arr_rdata;
   logic [c_strb_w-1:0]   w_wstrb;
   logic [63:0]           w_widx, w_ridx;
   logic                  w_wr_ok, w_rd_ok;
   logic                  w_unused_wlast;

   // Readies are held low while reset is asserted, not just by the cleared state.
   assign s_axi_awready = !s_axi_reset && !aw_full_q && !bvalid_q;
   assign s_axi_wready  = !s_axi_reset && !w_full_q  && !bvalid_q;
   assign s_axi_arready = !s_axi_reset && !rvalid_q;

   assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_w_hs   = s_axi_wvalid  && s_axi_wready;
   assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
   assign w_commit = (aw_full_q || w_aw_hs) && (w_full_q || w_w_hs);

   assign w_waddr = aw_full_q ? aw_addr_q : s_axi_awaddr;
   assign w_wdata = w_full_q  ? w_data_q  : s_axi_wdata;
   assign w_wstrb = w_full_q  ? w_strb_q  : s_axi_wstrb;

   assign w_widx  = word_index(64'(w_waddr), DATA_WIDTH);
   assign w_ridx  = word_index(64'(s_axi_araddr), DATA_WIDTH);
   assign w_wr_ok = w_widx < 64'(NUM_REGS);
   assign w_rd_ok = w_ridx < 64'(NUM_REGS);

   assign w_unused_wlast = s_axi_wlast;

   axi_lite_reg_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_REGS    (NUM_REGS),
      .IDX_W       (c_idx_w),
      .RESET_VALUE (RESET_VALUE)
   ) u_reg_array (
      .clk     (s_axi_clk),
      .rst     (s_axi_reset),
      .we_i    (w_commit && w_wr_ok),
      .widx_i  (w_widx[c_idx_w-1:0]),
      .wdata_i (w_wdata),
      .wstrb_i (w_wstrb),
      .ridx_i  (w_ridx[c_idx_w-1:0]),
      .rdata_o (w_arr_rdata)
   );

   always_comb begin
      aw_full_d = aw_full_q;
      aw_addr_d = aw_addr_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;

      // While bvalid is high both readies are low, so a commit and a B
      // handshake can never land on the same edge.
      if (w_commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (w_aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
         end
         if (w_w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
         end
         if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
         end
      end

      if (w_ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         rdata_d  = w_rd_ok ? w_arr_rdata : '0;
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge s_axi_clk or posedge s_axi_reset) begin
      if (s_axi_reset) begin
         aw_full_q <= 1'b0;
         aw_addr_q <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rresp  = rresp_q;
   assign s_axi_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
// ============================================================================
// Module      : tb_axi_lite_regfile
// Description : Directed, table-driven bench for axi_lite_regfile (32b, 16 regs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b1;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [7:0]  araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;

   int nvec = 0;
   int nerr = 0;
   logic [31:0] model [16];

   always #5 clk = ~clk;

   axi_lite_regfile #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (8),
      .NUM_REGS    (16),
      .RESET_VALUE (32'h0)
   ) dut (
      .s_axi_clk     (clk),
      .s_axi_reset   (rst),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wlast   (wlast),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready)
   );

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
   endtask

   task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(a) / 4;
      if (idx < 16) begin
         for (int l = 0; l < 4; l++) begin
            if (s[l]) model[idx][8*l +: 8] = d[8*l +: 8];
         end
      end
   endtask

   // All helpers enter and leave on a falling edge.
   task automatic get_b(output logic [1:0] resp);
      int n;
      for (n = 0; n < 50 && !bvalid; n++) @(negedge clk);
      if (n == 50) check("b_timeout", 32'd0, 32'd1);
      resp   = bresp;
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      int n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      for (n = 0; n < 50 && !(awready && wready); n++) @(negedge clk);
      if (n == 50) check("aw_w_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(a, d, s);
      get_b(resp);
   endtask

   task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      araddr = a; arvalid = 1'b1;
      for (n = 0; n < 50 && !arready; n++) @(negedge clk);
      if (n == 50) check("ar_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      for (n = 0; n < 50 && !rvalid; n++) @(negedge clk);
      if (n == 50) check("r_timeout", 32'd0, 32'd1);
      d = rdata; resp = rresp;
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
   endtask

   // Sends one channel, waits gap cycles, then the other channel.
   task automatic split_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                              input bit aw_first, input int gap);
      logic [1:0] resp;
      awaddr = a; wdata = d; wstrb = s;
      for (int ph = 0; ph < 2; ph++) begin
         if ((ph == 0) == aw_first) awvalid = 1'b1;
         else                       wvalid  = 1'b1;
         @(posedge clk);
         @(negedge clk);
         awvalid = 1'b0; wvalid = 1'b0;
         if (ph == 0) begin
            repeat (gap - 1) @(negedge clk);
            check("split_no_early_b", 32'(bvalid), 32'd0);
         end
      end
      check("split_bvalid", 32'(bvalid), 32'd1);
      model_write(a, d, s);
      get_b(resp);
      check("split_bresp", 32'(resp), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;

      tbl[0]  = '{1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
      tbl[1]  = '{1'b1, 8'h10, 32'h12345678, 4'h0, 32'h0,        2'b00};
      tbl[2]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
      tbl[3]  = '{1'b1, 8'h13, 32'h0000BB00, 4'h2, 32'h0,        2'b00};
      tbl[4]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hCAFEBB0D, 2'b00};
      tbl[5]  = '{1'b0, 8'h3C, 32'h0,        4'h0, 32'h00000000, 2'b00};
      tbl[6]  = '{1'b1, 8'h3C, 32'h87654321, 4'hF, 32'h0,        2'b00};
      tbl[7]  = '{1'b0, 8'h3E, 32'h0,        4'h0, 32'h87654321, 2'b00};
      tbl[8]  = '{1'b1, 8'hFC, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
      tbl[9]  = '{1'b0, 8'hFF, 32'h0,        4'h0, 32'h00000000, 2'b10};
      tbl[10] = '{1'b1, 8'h20, 32'h00FF00FF, 4'h9, 32'h0,        2'b00};
      tbl[11] = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h000000FF, 2'b00};

      model_reset();

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready",  32'(wready),  32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_rvalid",  32'(rvalid),  32'd0);
      check("rst_rdata",   rdata,        32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_awready", 32'(awready), 32'd1);
      check("post_rst_wready",  32'(wready),  32'd1);
      check("post_rst_arready", 32'(arready), 32'd1);
      do_read(8'h00, d, r);
      check("rd00_data", d, 32'h0);
      check("rd00_resp", 32'(r), 32'd0);

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
            check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].exp_resp));
         end else begin
            do_read(tbl[i].addr, d, r);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
            check($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].exp_resp));
         end
      end

      // AW and W in the same cycle: bvalid right after the commit edge.
      awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("same_cyc_bvalid", 32'(bvalid), 32'd1);
      model_write(8'h04, 32'hDEADBEEF, 4'hF);
      get_b(r);
      check("same_cyc_bresp", 32'(r), 32'd0);
      do_read(8'h04, d, r);
      check("rd04_data", d, 32'hDEADBEEF);

      // W three cycles ahead of AW, then AW-first, both strobed over 0xAAAAAAAA.
      do_write(8'h08, 32'hAAAAAAAA, 4'hF, r);
      split_write(8'h08, 32'h11223344, 4'h5, 1'b0, 3);
      do_read(8'h08, d, r);
      check("w_first_data", d, 32'hAA22AA44);
      do_write(8'h08, 32'hAAAAAAAA, 4'hF, r);
      split_write(8'h08, 32'h11223344, 4'h5, 1'b1, 3);
      do_read(8'h08, d, r);
      check("aw_first_data", d, 32'hAA22AA44);

      // Out-of-range write leaves every register untouched.
      do_write(8'h40, 32'h12345678, 4'hF, r);
      check("oor_bresp", 32'(r), 32'd2);
      do_read(8'h40, d, r);
      check("oor_rdata", d, 32'h0);
      check("oor_rresp", 32'(r), 32'd2);
      for (int i = 0; i < 16; i++) begin
         do_read(8'(i * 4), d, r);
         check($sformatf("scan_reg%0d", i), d, model[i]);
      end

      // B back-pressure with a second write already waiting.
      awaddr = 8'h18; wdata = 32'h0F0F0F0F; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_write(8'h18, 32'h0F0F0F0F, 4'hF);
      awaddr = 8'h1C; wdata = 32'h3C3C3C3C;
      for (int i = 0; i < 5; i++) begin
         check("hold_bvalid",  32'(bvalid),  32'd1);
         check("hold_bresp",   32'(bresp),   32'd0);
         check("hold_awready", 32'(awready), 32'd0);
         check("hold_wready",  32'(wready),  32'd0);
         @(negedge clk);
      end
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("hold_b_cleared", 32'(bvalid),  32'd0);
      check("hold_awready_up", 32'(awready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("second_bvalid", 32'(bvalid), 32'd1);
      model_write(8'h1C, 32'h3C3C3C3C, 4'hF);
      get_b(r);
      do_read(8'h18, d, r);
      check("rd18_data", d, 32'h0F0F0F0F);
      do_read(8'h1C, d, r);
      check("rd1c_data", d, 32'h3C3C3C3C);

      // Write commit and AR to the same register on one edge.
      do_write(8'h0C, 32'h9, 4'hF, r);
      awaddr = 8'h0C; wdata = 32'h5; wstrb = 4'hF; araddr = 8'h0C;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("coll_rvalid", 32'(rvalid), 32'd1);
      check("coll_rdata",  rdata,       32'h9);
      check("coll_bvalid", 32'(bvalid), 32'd1);
      model_write(8'h0C, 32'h5, 4'hF);
      rready = 1'b1; bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0; bready = 1'b0;
      do_read(8'h0C, d, r);
      check("coll_next_rdata", d, 32'h5);

      // Reset with only W buffered: the write must never land.
      wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wvalid = 1'b0;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_wready", 32'(wready), 32'd1);
      do_read(8'h14, d, r);
      check("midrst_reg14", d, 32'h0);
      do_read(8'h04, d, r);
      check("midrst_reg04", d, 32'h0);
      split_write(8'h14, 32'h55, 4'hF, 1'b1, 3);
      do_read(8'h14, d, r);
      check("midrst_rd14_after", d, 32'h55);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
